cp_corr_accum: RTL and testbench
================================

// Module: cp_corr_accum
// PURPOSE
//  Consumes the current/delayed-by-N sample pair from the delay-N stage and forms the CP
//  sliding-window statistics for symbol timing / CFO estimation:
//    gamma(k) = sum_{i=0..L-1} r(k-i)*conj(r(k-i-N))
//    phi(k)   = sum_{i=0..L-1} |r(k-i)|^2 + |r(k-i-N)|^2
//  Feeds the timing-metric / peak-search stage.
// PARAMETERS
//  DW  16  sample width (signed two's complement, matches r_t)
//  L   16  CP length = window depth (>=2)
//  PW  2*DW+1  product width (derived, localparam)
//  AW  PW+2+$clog2(L)  accumulator width (derived, localparam)
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    async reset, ACTIVE-LOW (asserted when 0)
//  clr         in   1    sync window clear (new frame), active-high
//  in_valid    in   1    input sample valid (from delay_n_valid)
//  r_real      in   DW   current sample I
//  r_imag      in   DW   current sample Q
//  r_dN_real   in   DW   sample delayed N, I
//  r_dN_imag   in   DW   sample delayed N, Q
//  corr_valid  out  1    one-cycle strobe, window full and outputs updated
//  corr_re     out  AW   Re(gamma), signed
//  corr_im     out  AW   Im(gamma), signed
//  energy      out  AW   phi, unsigned
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs, stage regs, fill counter, sums, window RAM/regs = 0.
//  - Stage 1 (on in_valid=1): register p_re=rr*dr+ri*di, p_im=ri*dr-rr*di, e=rr^2+ri^2+dr^2+di^2
//    (full precision, no rounding/saturation); v1<=in_valid every cycle.
//  - Stage 2 (on v1=1): push (p_re,p_im,e) into L-deep window; sums += new - evicted entry.
//    Evicted entry = zero until L entries held (fill counter 0..L, saturates at L).
//  - corr_valid=1 exactly one cycle per accepted sample whose fill count after push == L.
//  - Latency: sample accepted at cycle t -> corr_* updated, corr_valid high at t+2.
//  - in_valid=0: no push, no output update; corr_* hold last value, corr_valid=0.
//    Gapped input yields bit-identical results to contiguous input (only valid samples count).
//  - Running sums: exact add/subtract, AW sized so no overflow; no drift over any length.
//  - clr=1: fill counter, sums, v1 and window contents cleared next edge; corr_valid=0 that
//    cycle; corr_* hold. clr with in_valid=1 same cycle: clr wins, sample discarded.
//    Sample in stage 1 at clr is also discarded. First post-clr strobe after L new samples.
//  - Reset mid-operation: immediate return to reset state; restart identical to clr.
//  - Window: circular buffer, wr pointer wraps L-1 -> 0; evicted = entry at wr pointer.
// CONFIGURATION
//  CP_CORR_MAG_EN defined: extra port corr_mag (out, AW, unsigned) =
//    max(|re|,|im|) + (min(|re|,|im|)>>1) of new gamma, registered with corr_re/im
//    (same t+2 latency, same hold/reset/clr rules, reset 0).
//  CP_CORR_MAG_EN undefined: port and logic absent; all else identical.
// TESTING (DW=16, L=4)
//  1 rst=0 mid-stream -> all outputs 0, corr_valid 0 same cycle; restart needs 4 samples.
//  2 r=(100,0), rdN=(100,0), 8 valid cycles -> first strobe 2 cyc after 4th sample;
//    corr_re=40000, corr_im=0, energy=80000; 5 strobes total.
//  3 r=(0,100), rdN=(100,0) steady -> corr_re=0, corr_im=40000, energy=80000;
//    MAG_EN: corr_mag=40000.
//  4 case 2 with in_valid pattern 1,0,0,1,... -> same values/strobe count as case 2,
//    strobes only 2 cyc after valid samples.
//  5 clr=1 with in_valid=1 after 6 samples -> that sample dropped, no strobe until
//    4 new samples, then sums from new samples only.
//  6 all inputs -32768 -> p_re=2^31, p_im=0, e=2^32; after 4: corr_re=2^33, energy=2^34,
//    no wrap.

Source files
------------

// File: rtl/cp_corr_accum.sv
// CP sliding-window correlator: running gamma (lag-N autocorrelation) and phi (energy) over L samples.
// Optional `CP_CORR_MAG_EN adds a corr_mag output (max + min/2 magnitude estimate of gamma).
module cp_corr_accum #(
    parameter  int DW = 16,
    parameter  int L  = 16,
    localparam int PW = 2*DW + 1,
    localparam int AW = PW + 2 + $clog2(L)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] r_real,
    input  logic signed [DW-1:0] r_imag,
    input  logic signed [DW-1:0] r_dN_real,
    input  logic signed [DW-1:0] r_dN_imag,
    output logic                 corr_valid,
    output logic signed [AW-1:0] corr_re,
    output logic signed [AW-1:0] corr_im,
    output logic        [AW-1:0] energy
`ifdef CP_CORR_MAG_EN
    ,
    output logic        [AW-1:0] corr_mag
`endif
);

    localparam int FW = $clog2(L + 1);
    localparam int WW = $clog2(L);
    localparam logic [FW-1:0] FILL_FULL = FW'(L);
    localparam logic [WW-1:0] WR_LAST   = WW'(L - 1);

    logic signed [PW-1:0] xr, xi, xdr, xdi;
    logic signed [PW-1:0] p_re_c, p_im_c, e_c;
    logic                 v1;
    logic signed [PW-1:0] p_re1, p_im1;
    logic        [PW-1:0] e1;

    logic signed [PW-1:0] win_re [L];
    logic signed [PW-1:0] win_im [L];
    logic        [PW-1:0] win_en [L];
    logic        [WW-1:0] wr;
    logic        [FW-1:0] fill, fill_n;
    logic signed [AW-1:0] sum_re, sum_im, sum_re_n, sum_im_n;
    logic        [AW-1:0] sum_en, sum_en_n;

    assign xr  = PW'(r_real);
    assign xi  = PW'(r_imag);
    assign xdr = PW'(r_dN_real);
    assign xdi = PW'(r_dN_imag);

    // Energy can reach 2^(PW-1); the bit pattern is kept and read back as unsigned.
    always_comb begin
        p_re_c = xr * xdr + xi * xdi;
        p_im_c = xi * xdr - xr * xdi;
        e_c    = xr * xr + xi * xi + xdr * xdr + xdi * xdi;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            p_re1 <= '0;
            p_im1 <= '0;
            e1    <= '0;
        end else if (clr) begin
            v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                p_re1 <= p_re_c;
                p_im1 <= p_im_c;
                e1    <= e_c;
            end
        end
    end

    // Window slots are zero until written, so the eviction term is zero while filling.
    always_comb begin
        sum_re_n = sum_re + AW'(p_re1) - AW'(win_re[wr]);
        sum_im_n = sum_im + AW'(p_im1) - AW'(win_im[wr]);
        sum_en_n = sum_en + AW'(e1)    - AW'(win_en[wr]);
        fill_n   = (fill == FILL_FULL) ? fill : fill + FW'(1);
    end

`ifdef CP_CORR_MAG_EN
    logic [AW-1:0] abs_re, abs_im, mag_n;
    always_comb begin
        abs_re = sum_re_n[AW-1] ? -sum_re_n : sum_re_n;
        abs_im = sum_im_n[AW-1] ? -sum_im_n : sum_im_n;
        mag_n  = (abs_re > abs_im) ? abs_re + (abs_im >> 1) : abs_im + (abs_re >> 1);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < L; i++) begin
                win_re[i] <= '0;
                win_im[i] <= '0;
                win_en[i] <= '0;
            end
            wr         <= '0;
            fill       <= '0;
            sum_re     <= '0;
            sum_im     <= '0;
            sum_en     <= '0;
            corr_valid <= 1'b0;
            corr_re    <= '0;
            corr_im    <= '0;
            energy     <= '0;
`ifdef CP_CORR_MAG_EN
            corr_mag   <= '0;
`endif
        end else if (clr) begin
            for (int unsigned i = 0; i < L; i++) begin
                win_re[i] <= '0;
                win_im[i] <= '0;
                win_en[i] <= '0;
            end
            wr         <= '0;
            fill       <= '0;
            sum_re     <= '0;
            sum_im     <= '0;
            sum_en     <= '0;
            corr_valid <= 1'b0;
        end else begin
            corr_valid <= 1'b0;
            if (v1) begin
                win_re[wr] <= p_re1;
                win_im[wr] <= p_im1;
                win_en[wr] <= e1;
                wr         <= (wr == WR_LAST) ? '0 : wr + WW'(1);
                fill       <= fill_n;
                sum_re     <= sum_re_n;
                sum_im     <= sum_im_n;
                sum_en     <= sum_en_n;
                corr_valid <= (fill_n == FILL_FULL);
                corr_re    <= sum_re_n;
                corr_im    <= sum_im_n;
                energy     <= sum_en_n;
`ifdef CP_CORR_MAG_EN
                corr_mag   <= mag_n;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cp_corr_accum.sv
// Bench for cp_corr_accum (DW=16, L=4): directed tables and sequences plus randomized stream
// compared against a window-of-samples reference model.
module tb_cp_corr_accum;

    localparam int DW = 16;
    localparam int L  = 4;
    localparam int AW = 2*DW + 1 + 2 + $clog2(L);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clr;
    logic                 in_valid;
    logic signed [DW-1:0] r_real, r_imag, r_dN_real, r_dN_imag;
    logic                 corr_valid;
    logic signed [AW-1:0] corr_re, corr_im;
    logic        [AW-1:0] energy;
`ifdef CP_CORR_MAG_EN
    logic        [AW-1:0] corr_mag;
`endif

    cp_corr_accum #(.DW(DW), .L(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .r_real     (r_real),
        .r_imag     (r_imag),
        .r_dN_real  (r_dN_real),
        .r_dN_imag  (r_dN_imag),
        .corr_valid (corr_valid),
        .corr_re    (corr_re),
        .corr_im    (corr_im),
        .energy     (energy)
`ifdef CP_CORR_MAG_EN
        ,
        .corr_mag   (corr_mag)
`endif
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;

    // Reference model: last L accepted sample products, one-deep pending (stage-1) slot.
    longint q_re[$], q_im[$], q_en[$];
    bit     pend_v;
    longint pend_re, pend_im, pend_en;
    bit     m_valid;
    longint m_re, m_im, m_en;
    bit     out_known;

    typedef struct {
        logic                 iv;
        logic signed [DW-1:0] rr, ri, dr, di;
        logic                 ev;
        longint               ere, eim, een;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint mag_of(input longint re, input longint im);
        longint ar, ai;
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        return (ar > ai) ? ar + (ai >> 1) : ai + (ar >> 1);
    endfunction

    task automatic model_reset();
        q_re.delete(); q_im.delete(); q_en.delete();
        pend_v = 0; m_valid = 0;
        m_re = 0; m_im = 0; m_en = 0;
        out_known = 1;
    endtask

    task automatic step(input logic iv, input logic c,
                        input logic signed [DW-1:0] a, b, d, e);
        longint sre, sim, sen;
        in_valid = iv; clr = c;
        r_real = a; r_imag = b; r_dN_real = d; r_dN_imag = e;
        @(posedge clk);
        m_valid = 0;
        if (c) begin
            q_re.delete(); q_im.delete(); q_en.delete();
            pend_v = 0;
        end else begin
            if (pend_v) begin
                q_re.push_back(pend_re); q_im.push_back(pend_im); q_en.push_back(pend_en);
                if (q_re.size() > L) begin
                    void'(q_re.pop_front()); void'(q_im.pop_front()); void'(q_en.pop_front());
                end
                sre = 0; sim = 0; sen = 0;
                foreach (q_re[i]) begin
                    sre += q_re[i]; sim += q_im[i]; sen += q_en[i];
                end
                if (q_re.size() == L) begin
                    m_valid = 1; out_known = 1;
                    m_re = sre; m_im = sim; m_en = sen;
                end else begin
                    out_known = 0;
                end
            end
            pend_v = iv;
            if (iv) begin
                pend_re = longint'(a) * d + longint'(b) * e;
                pend_im = longint'(b) * d - longint'(a) * e;
                pend_en = longint'(a) * a + longint'(b) * b + longint'(d) * d + longint'(e) * e;
            end
        end
        #1;
        if (corr_valid) strobes++;
        chk("corr_valid", longint'(corr_valid), longint'(m_valid));
        if (out_known) begin
            chk("corr_re", corr_re, m_re);
            chk("corr_im", corr_im, m_im);
            chk("energy", energy, m_en);
`ifdef CP_CORR_MAG_EN
            chk("corr_mag", corr_mag, mag_of(m_re, m_im));
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic do_clr();
        step(1'b0, 1'b1, '0, '0, '0, '0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", longint'(corr_valid), 0);
        chk("rst_re", corr_re, 0);
        chk("rst_im", corr_im, 0);
        chk("rst_energy", energy, 0);
`ifdef CP_CORR_MAG_EN
        chk("rst_mag", corr_mag, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
        r_real = '0; r_imag = '0; r_dN_real = '0; r_dN_imag = '0;
        model_reset();
        #12;
        chk("init_valid", longint'(corr_valid), 0);
        chk("init_re", corr_re, 0);
        chk("init_energy", energy, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // r=(100,0), rdN=(100,0), 8 valid then 2 idle: strobes after edges 4..8
        for (int k = 0; k < 10; k++) begin
            tbl[k].iv = (k < 8);
            tbl[k].rr = 16'sd100; tbl[k].ri = '0; tbl[k].dr = 16'sd100; tbl[k].di = '0;
            tbl[k].ev = (k >= 4 && k <= 8);
            tbl[k].ere = 40000; tbl[k].eim = 0; tbl[k].een = 80000;
        end
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].iv, 1'b0, tbl[k].rr, tbl[k].ri, tbl[k].dr, tbl[k].di);
            chk("tbl_valid", longint'(corr_valid), longint'(tbl[k].ev));
            if (tbl[k].ev) begin
                chk("tbl_re", corr_re, tbl[k].ere);
                chk("tbl_im", corr_im, tbl[k].eim);
                chk("tbl_energy", energy, tbl[k].een);
            end
        end
        chk("tbl_strobes", strobes, 5);
        chk("tbl_hold_re", corr_re, 40000);

        // r=(0,100), rdN=(100,0): pure imaginary correlation
        do_clr();
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 16'sd0, 16'sd100, 16'sd100, 16'sd0);
        chk("imag_re", corr_re, 0);
        chk("imag_im", corr_im, 40000);
        chk("imag_energy", energy, 80000);
`ifdef CP_CORR_MAG_EN
        chk("imag_mag", corr_mag, 40000);
`endif

        // Gapped input 1,0,0,... gives the same strobes and values as contiguous input
        do_clr();
        strobes = 0;
        for (int k = 0; k < 26; k++) begin
            step((k % 3 == 0) && (k < 24), 1'b0, 16'sd100, 16'sd0, 16'sd100, 16'sd0);
            if (corr_valid) chk("gap_re", corr_re, 40000);
        end
        chk("gap_strobes", strobes, 5);

        // clr with in_valid after 6 samples: that sample and the stage-1 sample are dropped
        do_clr();
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 16'sd100, 16'sd0, 16'sd100, 16'sd0);
        step(1'b1, 1'b1, 16'sd300, 16'sd0, 16'sd100, 16'sd0);
        chk("clr_hold_re", corr_re, 40000);
        strobes = 0;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'sd200, 16'sd0, 16'sd100, 16'sd0);
        chk("clr_no_early", strobes, 0);
        idle(1);
        chk("clr_strobes", strobes, 1);
        chk("clr_re", corr_re, 80000);
        chk("clr_energy", energy, 4 * 50000);

        // Full-scale negative inputs must not wrap
        do_clr();
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
        chk("max_re", corr_re, 64'sd1 << 33);
        chk("max_im", corr_im, 0);
        chk("max_energy", energy, 64'sd1 << 34);

        // Randomized stream with mid-stream reset, restart must need L samples
        for (int k = 0; k < 40; k++)
            step($urandom_range(0, 9) < 7, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
        async_reset();
        strobes = 0;
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
        chk("rst_restart_none", strobes, 0);
        idle(1);
        chk("rst_restart_one", strobes, 1);

        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                 DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
